fair_queue: RTL and testbench

- Work-conserving round-robin fair-queue arbiter that merges 2**NUM_IN_LOG2 input FIFOs onto one 64-bit output stream.
- Each cycle it pops at most one word, taken from the next non-empty FIFO after the last one served, and presents that word one cycle later.
- Sits between per-flow show-ahead FIFOs and a single downstream consumer that is always ready (no backpressure).

---
 rtl/fair_queue.sv | 57 +++++
 tb/tb_fair_queue.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fair_queue.sv
// Round-robin fair-queue arbiter: merges 2**NUM_IN_LOG2 show-ahead FIFOs onto one
// 64-bit stream, popping at most one word per cycle and presenting it a cycle later.
module fair_queue #(
   parameter int NUM_IN_LOG2 = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fifo_empty [2**NUM_IN_LOG2-1:0],
   input  logic [63:0] fifo_data  [2**NUM_IN_LOG2-1:0],
   output logic        fifo_rdreq [2**NUM_IN_LOG2-1:0],
   output logic        output_data_valid,
   output logic [63:0] output_data
);

   localparam int N = 2**NUM_IN_LOG2;

   logic [NUM_IN_LOG2-1:0] last_grant;
   logic [NUM_IN_LOG2-1:0] grant;
   logic [NUM_IN_LOG2-1:0] cand;
   logic                   grant_valid;

   // Scan from last_grant+1 around to last_grant itself; the index wraps naturally.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      cand        = '0;
      for (int k = 1; k <= N; k++) begin
         cand = last_grant + NUM_IN_LOG2'(k);
         if (!grant_valid && !fifo_empty[cand]) begin
            grant       = cand;
            grant_valid = 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         fifo_rdreq[i] = rst && grant_valid && (grant == NUM_IN_LOG2'(i));
      end
   end

   // Reset restarts priority at input 0 and drops any in-flight word.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_grant        <= NUM_IN_LOG2'(N - 1);
         output_data_valid <= 1'b0;
         output_data       <= 64'h0;
      end else if (grant_valid) begin
         last_grant        <= grant;
         output_data_valid <= 1'b1;
         output_data       <= fifo_data[grant];
      end else begin
         output_data_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fair_queue.sv
// Testbench for fair_queue: directed scenarios plus random traffic, checked against
// a round-robin reference model driven from the same per-cycle input masks.
module tb_fair_queue;

   localparam int NUM_IN_LOG2 = 3;
   localparam int N = 2**NUM_IN_LOG2;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_empty [N-1:0];
   logic [63:0] fifo_data  [N-1:0];
   logic        fifo_rdreq [N-1:0];
   logic        output_data_valid;
   logic [63:0] output_data;

   int compared   = 0;
   int mismatched = 0;

   int          model_last  = N - 1;
   logic        model_valid = 1'b0;
   logic [63:0] model_data  = 64'h0;

   always #5 clk = ~clk;

   fair_queue #(.NUM_IN_LOG2(NUM_IN_LOG2)) dut (
      .clk               (clk),
      .rst               (rst),
      .fifo_empty        (fifo_empty),
      .fifo_data         (fifo_data),
      .fifo_rdreq        (fifo_rdreq),
      .output_data_valid (output_data_valid),
      .output_data       (output_data)
   );

   function automatic int expGrant();
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (model_last + k) % N;
         if (!fifo_empty[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic applyStimulus(input logic rst_val, input logic [N-1:0] active, input bit rand_data);
      rst = rst_val;
      for (int i = 0; i < N; i++) begin
         fifo_empty[i] = ~active[i];
         fifo_data[i]  = rand_data ? {$urandom, $urandom} : 64'(i + 1);
      end
   endtask

   // Pop strobes are checked mid-cycle; registered outputs just after the edge.
   task automatic checkOutput();
      int          g;
      logic [N-1:0] exp_req;
      logic [N-1:0] got_req;
      @(negedge clk);
      g = rst ? expGrant() : -1;
      exp_req = '0;
      if (g >= 0) exp_req[g] = 1'b1;
      for (int i = 0; i < N; i++) got_req[i] = fifo_rdreq[i];
      compared++;
      assert (got_req === exp_req) else begin
         mismatched++;
         $error("[TB] FAIL rdreq: observed %b expected %b", got_req, exp_req);
      end
      @(posedge clk);
      if (!rst) begin
         model_last  = N - 1;
         model_valid = 1'b0;
         model_data  = 64'h0;
      end else if (g >= 0) begin
         model_last  = g;
         model_valid = 1'b1;
         model_data  = fifo_data[g];
      end else begin
         model_valid = 1'b0;
      end
      #1;
      compared++;
      assert (output_data_valid === model_valid) else begin
         mismatched++;
         $error("[TB] FAIL valid: observed %b expected %b", output_data_valid, model_valid);
      end
      compared++;
      assert (output_data === model_data) else begin
         mismatched++;
         $error("[TB] FAIL data: observed %h expected %h", output_data, model_data);
      end
   endtask

   task automatic runCycles(input logic rst_val, input logic [N-1:0] active, input bit rand_data, input int n);
      repeat (n) begin
         applyStimulus(rst_val, active, rand_data);
         checkOutput();
      end
   endtask

   initial begin
      logic [N-1:0] mask;
      $display("[TB] fair_queue bench start, N=%0d", N);

      runCycles(1'b0, '1, 1'b0, 2);
      runCycles(1'b1, '1, 1'b0, 18);

      mask = '0; mask[2] = 1'b1; mask[5] = 1'b1;
      runCycles(1'b1, mask, 1'b1, 6);

      runCycles(1'b1, '0, 1'b1, 3);
      mask = '0; mask[7] = 1'b1;
      runCycles(1'b1, mask, 1'b1, 4);

      mask = '0; mask[6] = 1'b1;
      runCycles(1'b1, mask, 1'b1, 1);
      mask[1] = 1'b1;
      runCycles(1'b1, mask, 1'b1, 3);

      mask = '0; mask[3] = 1'b1;
      runCycles(1'b1, mask, 1'b1, 2);
      mask[0] = 1'b1;
      runCycles(1'b0, mask, 1'b1, 1);
      runCycles(1'b1, mask, 1'b1, 3);

      for (int c = 0; c < 300; c++) begin
         case ($urandom_range(0, 3))
            0:       mask = N'($urandom);
            1:       mask = N'($urandom) & N'($urandom) & N'($urandom);
            2:       mask = '0;
            default: mask = N'(1) << $urandom_range(0, N - 1);
         endcase
         runCycles(($urandom_range(0, 31) != 0), mask, 1'b1, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
